// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: access-size codes and the
// clear/idle state encoding used by data_memory.
package data_memory_pkg;

   // Access-size codes presented on i_word_size by the MEM stage
   localparam logic [2:0] BYTE_WORD     = 3'b000;
   localparam logic [2:0] HALF_WORD     = 3'b001;
   localparam logic [2:0] COMPLETE_WORD = 3'b010;

   // Memory controller states: CLEAR sweeps zeros into every word after
   // reset, IDLE serves pipeline accesses.
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } mem_state_e;

endpackage

// File: rtl/data_memory_lane_sel.sv
// Combinational lane logic for the data memory: decodes the access size
// and low address bits into byte enables, replicates store data onto the
// lanes, and right-justifies the addressed lane(s) of a stored word.
// With DATA_MEM_ALIGN_CHECK_EN defined, misaligned half/word accesses are
// flagged on o_misaligned; otherwise alignment bits are simply truncated.
module data_memory_lane_sel
   import data_memory_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int TYPE      = 3
) (
   input  logic [TYPE-1:0]      i_word_size,
   input  logic [1:0]           i_addr_lo,
   input  logic [DATA_SIZE-1:0] i_write_data,
   input  logic [DATA_SIZE-1:0] i_mem_word,
   output logic [3:0]           o_byte_en,
   output logic [DATA_SIZE-1:0] o_write_word,
   output logic [DATA_SIZE-1:0] o_read_lane,
   output logic                 o_legal,
   output logic                 o_misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the stored word
   always_comb begin
      byte_sel = i_mem_word[{i_addr_lo, 3'b000} +: 8];
      half_sel = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
   end

   // Size decode: enables, lane-replicated store data, justified load data
   always_comb begin
      o_byte_en    = 4'b0000;
      o_write_word = '0;
      o_read_lane  = '0;
      o_legal      = 1'b0;
      case (i_word_size)
         TYPE'(BYTE_WORD): begin
            o_legal      = 1'b1;
            o_byte_en    = 4'b0001 << i_addr_lo;
            o_write_word = DATA_SIZE'({4{i_write_data[7:0]}});
            o_read_lane  = DATA_SIZE'(byte_sel);
         end
         TYPE'(HALF_WORD): begin
            o_legal      = 1'b1;
            o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_write_word = DATA_SIZE'({2{i_write_data[15:0]}});
            o_read_lane  = DATA_SIZE'(half_sel);
         end
         TYPE'(COMPLETE_WORD): begin
            o_legal      = 1'b1;
            o_byte_en    = 4'b1111;
            o_write_word = i_write_data;
            o_read_lane  = i_mem_word;
         end
         default: begin
            o_legal = 1'b0;
         end
      endcase
   end

`ifdef DATA_MEM_ALIGN_CHECK_EN
   // Halfwords must sit on even bytes, words on multiples of four
   always_comb begin
      o_misaligned = 1'b0;
      if (i_word_size == TYPE'(HALF_WORD) && i_addr_lo[0]) begin
         o_misaligned = 1'b1;
      end else if (i_word_size == TYPE'(COMPLETE_WORD) && i_addr_lo != 2'b00) begin
         o_misaligned = 1'b1;
      end
   end
`else
   assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory for the MEM stage. After reset a CLEAR sweep
// writes zero into every word (o_ready low), then IDLE serves byte/half/
// word stores and synchronous loads with read-before-write semantics, plus
// a registered debug read port. Optional alignment fault checking is
// enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = 32,
   parameter int DEPTH     = 256,
   parameter int TYPE      = 3
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_write,
   input  logic                 i_read,
   input  logic [TYPE-1:0]      i_word_size,
   input  logic [ADDR_SIZE-1:0] i_addr,
   input  logic [DATA_SIZE-1:0] i_write_data,
   output logic [DATA_SIZE-1:0] o_read_data,
   input  logic [ADDR_SIZE-1:0] i_debug_addr,
   output logic [DATA_SIZE-1:0] o_debug_data,
   output logic                 o_ready,
   output logic                 o_misaligned
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];

   mem_state_e           state_q, state_d;
   logic [IDX_W-1:0]     cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic [DATA_SIZE-1:0] read_q, read_d;
   logic [DATA_SIZE-1:0] debug_q, debug_d;
   logic                 mis_q, mis_d;

   logic [IDX_W-1:0]     word_idx;
   logic [IDX_W-1:0]     debug_idx;
   logic [DATA_SIZE-1:0] mem_word;
   logic [3:0]           byte_en;
   logic [DATA_SIZE-1:0] write_word;
   logic [DATA_SIZE-1:0] read_lane;
   logic                 size_legal;
   logic                 lane_mis;
   logic                 acc_rd;
   logic                 acc_wr;
   logic                 store_en_d;
   logic                 unused_addr_bits;

   // Upper address bits wrap the index; debug low bits are word-aligned
   assign word_idx  = i_addr[IDX_W+1:2];
   assign debug_idx = i_debug_addr[IDX_W+1:2];
   assign unused_addr_bits = ^{i_addr[ADDR_SIZE-1:IDX_W+2],
                               i_debug_addr[ADDR_SIZE-1:IDX_W+2],
                               i_debug_addr[1:0]};

   assign mem_word = mem_q[word_idx];

   data_memory_lane_sel #(
      .DATA_SIZE (DATA_SIZE),
      .TYPE      (TYPE)
   ) u_lane_sel (
      .i_word_size  (i_word_size),
      .i_addr_lo    (i_addr[1:0]),
      .i_write_data (i_write_data),
      .i_mem_word   (mem_word),
      .o_byte_en    (byte_en),
      .o_write_word (write_word),
      .o_read_lane  (read_lane),
      .o_legal      (size_legal),
      .o_misaligned (lane_mis)
   );

   // Pipeline requests only count once the clear sweep has finished
   assign acc_rd = i_read  & ready_q;
   assign acc_wr = i_write & ready_q;

   // Next-state logic of the clear/idle controller
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end
         end
         ST_IDLE: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   // Load, debug and fault outputs; the memory is read before any store
   always_comb begin
      store_en_d = acc_wr & size_legal & ~lane_mis;
      read_d     = read_q;
      if (acc_rd && !lane_mis) begin
         read_d = read_lane;
      end
      mis_d   = (acc_rd | acc_wr) & lane_mis;
      debug_d = mem_q[debug_idx];
   end

   // Controller state register with registered ready
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Output registers cleared immediately by reset
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         read_q  <= '0;
         debug_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         read_q  <= read_d;
         debug_q <= debug_d;
         mis_q   <= mis_d;
      end
   end

   // Storage: zero sweep while clearing, lane-masked stores when idle
   always_ff @(posedge i_clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (store_en_d && byte_en[l]) begin
               mem_q[word_idx][l*8 +: 8] <= write_word[l*8 +: 8];
            end
         end
      end
   end

   assign o_read_data  = read_q;
   assign o_debug_data = debug_q;
   assign o_ready      = ready_q;
   assign o_misaligned = mis_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus updates a word-array reference
// model and queues expected outputs; a monitor pops and compares them.
module tb_data_memory;
   import data_memory_pkg::*;

   localparam int DEPTH = 256;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_write;
   logic        i_read;
   logic [2:0]  i_word_size;
   logic [31:0] i_addr;
   logic [31:0] i_write_data;
   logic [31:0] o_read_data;
   logic [31:0] i_debug_addr;
   logic [31:0] o_debug_data;
   logic        o_ready;
   logic        o_misaligned;

   always #5 i_clk = ~i_clk;

   data_memory #(
      .DATA_SIZE (32),
      .ADDR_SIZE (32),
      .DEPTH     (DEPTH),
      .TYPE      (3)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_write      (i_write),
      .i_read       (i_read),
      .i_word_size  (i_word_size),
      .i_addr       (i_addr),
      .i_write_data (i_write_data),
      .o_read_data  (o_read_data),
      .i_debug_addr (i_debug_addr),
      .o_debug_data (o_debug_data),
      .o_ready      (o_ready),
      .o_misaligned (o_misaligned)
   );

   typedef struct {
      int          due;
      int          kind;
      logic [31:0] value;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   // Reference model: plain word array, held load result, clear progress
   logic [31:0] m_mem   [DEPTH];
   bit          m_known [DEPTH];
   logic [31:0] m_rd;
   int          m_clr;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit m_legal(input logic [2:0] sz);
      return (sz == BYTE_WORD) || (sz == HALF_WORD) || (sz == COMPLETE_WORD);
   endfunction

   function automatic bit m_mis(input logic [2:0] sz, input logic [31:0] a);
`ifdef DATA_MEM_ALIGN_CHECK_EN
      return ((sz == HALF_WORD) && (a % 2 != 0)) || ((sz == COMPLETE_WORD) && (a % 4 != 0));
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: compare every queued expectation that falls due this cycle
   always @(negedge i_clk) begin
      if (!i_reset) begin
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            case (e.kind)
               0:       check("read_data",  o_read_data,          e.value);
               1:       check("debug_data", o_debug_data,         e.value);
               2:       check("misaligned", {31'b0, o_misaligned}, e.value);
               default: check("ready",      {31'b0, o_ready},      e.value);
            endcase
         end
      end
   end

   // One clock of stimulus; the model advances with the same edge
   task automatic op(input bit rd, input bit wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] dbg);
      int          wi, di, lane, h;
      logic [31:0] w, dbg_exp, mask;
      bit          dbg_known, mis, legal;
      logic [31:0] mis_exp;
      i_read       = rd;
      i_write      = wr;
      i_word_size  = sz;
      i_addr       = a;
      i_write_data = wd;
      i_debug_addr = dbg;
      @(posedge i_clk);
      wi        = int'((a >> 2) % DEPTH);
      di        = int'((dbg >> 2) % DEPTH);
      dbg_known = m_known[di];
      dbg_exp   = m_mem[di];
      mis_exp   = 32'd0;
      if (m_clr < DEPTH) begin
         m_mem[m_clr]   = 32'd0;
         m_known[m_clr] = 1'b1;
         m_clr++;
      end else begin
         legal = m_legal(sz);
         mis   = legal && m_mis(sz, a);
         lane  = int'(a % 4);
         h     = int'((a >> 1) % 2);
         w     = m_mem[wi];
         if ((rd || wr) && mis) mis_exp = 32'd1;
         if (rd && !mis) begin
            case (sz)
               BYTE_WORD:     m_rd = (w >> (8 * lane)) & 32'hFF;
               HALF_WORD:     m_rd = (w >> (16 * h)) & 32'hFFFF;
               COMPLETE_WORD: m_rd = w;
               default:       m_rd = 32'd0;
            endcase
         end
         if (wr && legal && !mis) begin
            case (sz)
               BYTE_WORD: begin
                  mask = 32'hFF << (8 * lane);
                  w = (w & ~mask) | ((wd & 32'hFF) << (8 * lane));
               end
               HALF_WORD: begin
                  mask = 32'hFFFF << (16 * h);
                  w = (w & ~mask) | ((wd & 32'hFFFF) << (16 * h));
               end
               default: w = wd;
            endcase
            m_mem[wi]   = w;
            m_known[wi] = 1'b1;
         end
      end
      #1;
      sb_q.push_back('{cyc, 0, m_rd});
      if (dbg_known) sb_q.push_back('{cyc, 1, dbg_exp});
      sb_q.push_back('{cyc, 2, mis_exp});
      sb_q.push_back('{cyc, 3, (m_clr >= DEPTH) ? 32'd1 : 32'd0});
   endtask

   // Asynchronous reset: outputs must clear without waiting for an edge
   task automatic do_reset(input int hold);
      @(negedge i_clk);
      #1;
      i_reset = 1'b1;
      i_read  = 1'b0;
      i_write = 1'b0;
      #1;
      check("rst_ready",      {31'b0, o_ready},      32'd0);
      check("rst_read_data",  o_read_data,           32'd0);
      check("rst_debug_data", o_debug_data,          32'd0);
      check("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
      repeat (hold) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      m_clr   = 0;
      m_rd    = 32'd0;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
   endtask

   function automatic logic [2:0] rand_size();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) return BYTE_WORD;
      if (r < 6) return HALF_WORD;
      if (r < 9) return COMPLETE_WORD;
      return 3'($urandom_range(3, 7));
   endfunction

   task automatic rand_op();
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_size(), a,
         $urandom, $urandom & 32'hFFFF_FFFC);
   endtask

   initial begin
      i_reset      = 1'b1;
      i_read       = 1'b0;
      i_write      = 1'b0;
      i_word_size  = BYTE_WORD;
      i_addr       = 32'd0;
      i_write_data = 32'd0;
      i_debug_addr = 32'd0;
      m_rd         = 32'd0;
      m_clr        = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]   = 32'd0;
         m_known[i] = 1'b0;
      end

      do_reset(3);
      // Partial sweep with ignored traffic, then a reset at count 100
      repeat (100) rand_op();
      do_reset(2);
      repeat (DEPTH) rand_op();

      // Every word reads zero after the sweep
      for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b0, BYTE_WORD, 32'd0, 32'd0, 32'(i * 4));

      // Merged stores and narrow loads
      op(1'b0, 1'b1, COMPLETE_WORD, 32'h10, 32'hAABBCCDD, 32'h10);
      op(1'b0, 1'b1, BYTE_WORD,     32'h12, 32'h11,       32'h10);
      op(1'b1, 1'b0, COMPLETE_WORD, 32'h10, 32'h0,        32'h10);
      op(1'b1, 1'b0, HALF_WORD,     32'h12, 32'h0,        32'h10);
      op(1'b1, 1'b0, BYTE_WORD,     32'h13, 32'h0,        32'h10);
      op(1'b0, 1'b0, BYTE_WORD,     32'h0,  32'h0,        32'h10);

      // Read-before-write on the same word
      op(1'b0, 1'b1, COMPLETE_WORD, 32'h20, 32'h1, 32'h20);
      op(1'b1, 1'b1, COMPLETE_WORD, 32'h20, 32'h2, 32'h20);
      op(1'b1, 1'b0, COMPLETE_WORD, 32'h20, 32'h0, 32'h20);

      // Misaligned word store, then look at the word it would hit
      op(1'b0, 1'b1, COMPLETE_WORD, 32'h22, 32'h5, 32'h20);
      op(1'b1, 1'b0, COMPLETE_WORD, 32'h20, 32'h0, 32'h20);
      op(1'b1, 1'b0, HALF_WORD,     32'h23, 32'h0, 32'h20);
      op(1'b0, 1'b0, BYTE_WORD,     32'h0,  32'h0, 32'h20);

      // Illegal size: store dropped, load gives zero
      op(1'b1, 1'b1, 3'd5,          32'h20, 32'hDEAD, 32'h20);
      op(1'b1, 1'b0, COMPLETE_WORD, 32'h20, 32'h0,    32'h20);

      // Index wraps modulo DEPTH
      op(1'b0, 1'b1, COMPLETE_WORD, 32'h430,      32'h12345678, 32'h30);
      op(1'b1, 1'b0, COMPLETE_WORD, 32'hFFF0_0030, 32'h0,       32'h30);

      repeat (800) rand_op();
      repeat (3) op(1'b0, 1'b0, BYTE_WORD, 32'd0, 32'd0, 32'd0);

      @(negedge i_clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
